imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Boot-time writer for the pipelined core's instruction memory. Accepts a byte stream, packs it
//  into 32-bit little-endian words and writes them to imem. Holds the core in reset until the image
//  is loaded and its checksum verifies. In hardware it replaces file-based memory preloading.
//  Sits between the host byte link and the imem write port. Drives the core's rst_n.
// PARAMETERS
//  ADDR_W   8   imem word-address width; capacity = 2**ADDR_W words
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  s_valid      in   1       stream byte valid
//  s_data       in   8       stream byte
//  s_ready      out  1       loader accepts byte (transfer = s_valid & s_ready)
//  restart      in   1       sync pulse: abort or finish, then begin a new load
//  imem_we      out  1       imem word write strobe (1-cycle pulse)
//  imem_addr    out  ADDR_W  imem word index (not byte PC)
//  imem_wdata   out  32      instruction word
//  core_rst_n   out  1       active-low reset to the pipelined core
//  load_done    out  1       image loaded, checksum OK
//  load_err     out  1       length or checksum error
// BEHAVIOUR
//  Stream format: N[7:0], N[15:8], then 4*N payload bytes (word k: byte0 -> bits 7:0 .. byte3 -> 31:24),
//    then CSUM = XOR of all payload bytes. Header bytes are excluded from CSUM.
//  Reset (async, rst_n=0) values:
//    - state=HDR0; imem_we=0, imem_addr=0, imem_wdata=0
//    - core_rst_n=0, load_done=0, load_err=0; XOR accumulator=0, byte/word counters=0
//  FSM states: HDR0 -> HDR1 -> DATA -> CSUM -> DONE | ERR.
//    - HDR0, HDR1: capture N low byte, then high byte.
//    - After HDR1: if N > 2**ADDR_W go to ERR. If N==0 go to CSUM. Otherwise go to DATA.
//    - DATA: a 2-bit byte counter packs bytes into the word. On the 4th accepted byte, the next cycle
//      has imem_we=1 with the assembled word at imem_addr=k (registered, 1-cycle latency).
//      k increments once per word. After word N-1 the FSM goes to CSUM.
//    - CSUM: on acceptance, if byte == accumulator go to DONE, else go to ERR.
//  s_ready = (state in HDR0..CSUM) & ~restart. It is 0 in DONE and ERR.
//  DONE: load_done=1 and core_rst_n=1, both registered, in the cycle after the CSUM byte is accepted.
//  ERR: load_err=1. core_rst_n stays 0. No further imem writes.
//  restart=1 in any state:
//    - next state HDR0; counters and accumulator cleared
//    - core_rst_n=0, load_done=0, load_err=0
//    - a byte presented in the same cycle is not accepted
//    - a pending imem_we still completes; words already written are not erased
//  Restart mid-load aborts the load. A restart during DONE re-holds the core in reset.
//  Idle gaps (s_valid=0) are allowed anywhere in the stream; state is held.
//  N == 2**ADDR_W is legal; the last write goes to imem_addr = 2**ADDR_W - 1 (no wrap).
// STRUCTURE
//  loader_pkg:
//    - state enum (HDR0, HDR1, DATA, CSUM, DONE, ERR)
//    - HDR_W=16, WORD_BYTES=4, CSUM_W=8
//  Sub-module byte_packer:
//    - inputs: byte, accept strobe, clear
//    - outputs: 32-bit word, word_valid pulse
//    - owns the 2-bit byte counter and shift assembly
//  Top level owns the FSM, word counter, XOR accumulator and reset-control outputs.
// TESTING
//  1) Bytes 01 00 B3 06 98 01 2C -> one write, addr 0, data 0x019806B3; load_done=1, core_rst_n=1
//     one cycle after 2C is accepted.
//  2) Same stream, CSUM=2D -> no load_done; load_err=1; core_rst_n stays 0; s_ready=0.
//  3) N=0: bytes 00 00 00 -> no imem_we; load_done=1.
//  4) ADDR_W=8, header 01 01 (N=257) -> ERR right after HDR1; zero writes.
//  5) N=2, restart pulsed after the 5th payload byte, then a full N=1 stream ->
//     word 0 written twice (old, then new); final load_done=1, no write to addr 1.
//  6) N=3 with random s_valid gaps, and rst_n dropped mid-DATA -> all outputs at reset values
//     immediately; a subsequent clean load succeeds.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and sizes for the imem boot loader.
// Pure declarations; no logic, no latency.
// No flow control here; the users of these types handle handshakes.
package loader_pkg;

  // Load sequence: two length bytes, the payload, the checksum byte, then an end state
  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam int HDR_W      = 16;
  localparam int WORD_BYTES = 4;
  localparam int CSUM_W     = 8;

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words (first byte -> bits 7:0).
// word and word_vld are registered and appear one cycle after the 4th byte is accepted.
// Never stalls; it takes a byte whenever in_acc is high. word_last flags the 4th byte in that same cycle.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CSUM_W-1:0] in_byte,
  input  logic              in_acc,
  input  logic              clear,
  output logic              word_last,
  output logic [31:0]       word,
  output logic              word_vld
);

  logic [1:0]  cnt;
  logic [23:0] shift;

  // The byte being accepted completes a word
  assign word_last = in_acc && (cnt == 2'(WORD_BYTES - 1));

  // Shift in bytes from the top so the oldest byte ends up in the low lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      shift    <= '0;
      word     <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= 1'b0;
      if (clear) begin
        cnt   <= '0;
        shift <= '0;
      end else if (in_acc) begin
        cnt   <= cnt + 2'd1;
        shift <= {in_byte, shift[23:8]};
        if (word_last) begin
          word     <= {in_byte, shift};
          word_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into imem and releases core reset on success.
// An imem write happens 1 cycle after the 4th byte of a word is accepted; done/err/core_rst_n change 1 cycle after the deciding byte.
// s_ready is low in DONE/ERR and while restart is high. Otherwise every valid byte is taken at once.
module imem_boot_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned CAP = 2 ** ADDR_W;

  state_t            state;
  logic [7:0]        n_lo;
  logic [HDR_W-1:0]  n_words;
  logic [HDR_W-1:0]  word_cnt;
  logic [CSUM_W-1:0] acc;
  logic [HDR_W-1:0]  n_full;
  logic              accept;
  logic              pk_acc;
  logic              pk_last;

  assign s_ready = (state != DONE) && (state != ERR) && !restart;
  assign accept  = s_valid && s_ready;
  assign pk_acc  = accept && (state == DATA);
  assign n_full  = {s_data, n_lo};

  // A pending write pulse still leaves the packer after a restart. Only the partial word is dropped.
  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_byte   (s_data),
    .in_acc    (pk_acc),
    .clear     (restart),
    .word_last (pk_last),
    .word      (imem_wdata),
    .word_vld  (imem_we)
  );

  // Load sequencer: header capture, word counting, checksum and core-reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HDR0;
      n_lo       <= '0;
      n_words    <= '0;
      word_cnt   <= '0;
      acc        <= '0;
      imem_addr  <= '0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else if (restart) begin
      state      <= HDR0;
      word_cnt   <= '0;
      acc        <= '0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      case (state)
        HDR0: begin
          if (accept) begin
            n_lo  <= s_data;
            state <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            n_words <= n_full;
            if (32'(n_full) > CAP) begin
              state    <= ERR;
              load_err <= 1'b1;
            end else if (n_full == '0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            acc <= acc ^ s_data;
            if (pk_last) begin
              imem_addr <= word_cnt[ADDR_W-1:0];
              word_cnt  <= word_cnt + HDR_W'(1);
              if ((word_cnt + HDR_W'(1)) == n_words) begin
                state <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          if (accept) begin
            if (s_data == acc) begin
              state      <= DONE;
              load_done  <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end
        DONE: state <= DONE;
        ERR:  state <= ERR;
        default: state <= HDR0;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a write scoreboard.
// Expected imem writes are queued as words are sent and matched against imem_we pulses.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled on the falling edge or 1 ns after the rising edge.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        restart = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst_n;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  csum;

  imem_boot_loader #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .restart    (restart),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_count++;
      if (exp_addr.size() == 0) begin
        chk("spurious_we", 32'(imem_we), 32'd0);
      end else begin
        chk("wr_addr", 32'(imem_addr), exp_addr.pop_front());
        chk("wr_data", imem_wdata, exp_data.pop_front());
      end
    end
  end

  task automatic idle(input int k);
    s_valid = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one byte and hold it until accepted (bounded)
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   budget;
    rdy = 1'b0;
    budget = 50;
    s_valid = 1'b1;
    s_data  = b;
    while (!rdy && budget > 0) begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      budget--;
    end
    s_valid = 1'b0;
    chk("byte_accepted", 32'(rdy), 32'd1);
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    csum = 8'h00;
  endtask

  task automatic send_word(input logic [7:0] addr, input logic [31:0] w, input int maxgap);
    exp_addr.push_back(32'(addr));
    exp_data.push_back(w);
    for (int i = 0; i < 4; i++) begin
      if (maxgap > 0) idle($urandom_range(maxgap, 0));
      send_byte(w[8*i +: 8]);
      csum = csum ^ w[8*i +: 8];
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    @(negedge clk);
    chk("ready_during_restart", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    restart = 1'b0;
    s_valid = 1'b0;
    chk("restart_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("restart_done", 32'(load_done), 32'd0);
    chk("restart_err", 32'(load_err), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    int base;
    logic [31:0] w;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(s_ready), 32'd1);

    // 1) single word, good checksum
    base = wr_count;
    send_hdr(16'd1);
    exp_addr.push_back(32'd0);
    exp_data.push_back(32'h019806B3);
    send_byte(8'hB3); send_byte(8'h06); send_byte(8'h98); send_byte(8'h01);
    chk("t1_done_before_csum", 32'(load_done), 32'd0);
    chk("t1_core_held", 32'(core_rst_n), 32'd0);
    send_byte(8'h2C);
    chk("t1_done", 32'(load_done), 32'd1);
    chk("t1_core_rst_n", 32'(core_rst_n), 32'd1);
    chk("t1_ready_done", 32'(s_ready), 32'd0);
    chk("t1_writes", 32'(wr_count - base), 32'd1);

    // 2) same stream, bad checksum
    pulse_restart();
    base = wr_count;
    send_hdr(16'd1);
    exp_addr.push_back(32'd0);
    exp_data.push_back(32'h019806B3);
    send_byte(8'hB3); send_byte(8'h06); send_byte(8'h98); send_byte(8'h01);
    send_byte(8'h2D);
    chk("t2_err", 32'(load_err), 32'd1);
    chk("t2_done", 32'(load_done), 32'd0);
    chk("t2_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("t2_ready", 32'(s_ready), 32'd0);
    idle(3);
    chk("t2_err_held", 32'(load_err), 32'd1);
    chk("t2_writes", 32'(wr_count - base), 32'd1);

    // 3) empty image
    pulse_restart();
    base = wr_count;
    send_hdr(16'd0);
    send_byte(8'h00);
    chk("t3_done", 32'(load_done), 32'd1);
    chk("t3_core_rst_n", 32'(core_rst_n), 32'd1);
    idle(2);
    chk("t3_writes", 32'(wr_count - base), 32'd0);

    // 4) N=257 overflows capacity
    pulse_restart();
    chk("t4_restart_rehold", 32'(core_rst_n), 32'd0);
    base = wr_count;
    send_hdr(16'd257);
    chk("t4_err", 32'(load_err), 32'd1);
    chk("t4_ready", 32'(s_ready), 32'd0);
    idle(3);
    chk("t4_writes", 32'(wr_count - base), 32'd0);

    // 4b) N=256 fills imem exactly; last write at addr 255
    pulse_restart();
    base = wr_count;
    send_hdr(16'd256);
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'(i ^ 8'hA5), 8'(~i), 8'(i + 3)};
      send_word(8'(i), w, 0);
    end
    send_byte(csum);
    chk("t4b_done", 32'(load_done), 32'd1);
    chk("t4b_writes", 32'(wr_count - base), 32'd256);
    chk("t4b_last_addr", 32'(imem_addr), 32'd255);

    // 5) restart mid-load, then a new one-word load
    pulse_restart();
    base = wr_count;
    send_hdr(16'd2);
    send_word(8'd0, 32'h44332211, 0);
    send_byte(8'h55);
    pulse_restart();
    send_hdr(16'd1);
    send_word(8'd0, 32'hDDCCBBAA, 0);
    send_byte(csum);
    chk("t5_done", 32'(load_done), 32'd1);
    idle(2);
    chk("t5_writes", 32'(wr_count - base), 32'd2);

    // 6) gapped N=3 load killed by async reset mid-DATA, then a clean gapped load
    pulse_restart();
    send_hdr(16'd3);
    send_word(8'd0, $urandom, 3);
    idle(2);
    send_byte(8'h77);
    send_byte(8'h88);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    chk("t6_q_empty_after_rst", 32'(exp_addr.size()), 32'd0);
    base = wr_count;
    send_hdr(16'd3);
    for (int i = 0; i < 3; i++) send_word(8'(i), $urandom, 3);
    idle($urandom_range(3, 0));
    send_byte(csum);
    chk("t6_done", 32'(load_done), 32'd1);
    chk("t6_core_rst_n", 32'(core_rst_n), 32'd1);
    idle(2);
    chk("t6_writes", 32'(wr_count - base), 32'd3);
    chk("end_q_empty", 32'(exp_addr.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
